uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 132 +++++++++++++
 tb/tb_uart_rx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 serial receiver with oversampled, majority-voted mid-bit
//            sampling, one-cycle data/framing-error strobes.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_WIDTH   = 8,
    parameter int BAUDRATE     = 9600,
    parameter int CLK_FREQ_MHZ = 125,
    parameter int OVERSAMPLE   = 16,
    parameter int TICK_COUNT   = CLK_FREQ_MHZ * 1_000_000 / (BAUDRATE * OVERSAMPLE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid,
    output logic                  frame_err,
    output logic                  rx_busy
);

    localparam int c_TICK_W = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam int c_SAMP_W = $clog2(OVERSAMPLE);
    localparam int c_BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_COUNT - 1);
    localparam logic [c_SAMP_W-1:0] c_SAMP_LAST = c_SAMP_W'(OVERSAMPLE - 1);
    localparam logic [c_SAMP_W-1:0] c_MID       = c_SAMP_W'(OVERSAMPLE / 2);
    localparam logic [c_SAMP_W-1:0] c_MID_M1    = c_SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_SAMP_W-1:0] c_MID_M2    = c_SAMP_W'(OVERSAMPLE / 2 - 2);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t                r_state;
    logic [1:0]            r_sync;
    logic [c_TICK_W-1:0]   r_tick_cnt;
    logic [c_SAMP_W-1:0]   r_samp_cnt;
    logic [c_BIT_W-1:0]    r_bit_cnt;
    logic [2:0]            r_samp;
    logic                  r_decide;
    logic [DATA_WIDTH-1:0] r_shift;

    logic w_rx_s;
    logic w_tick;
    logic w_vote;

    assign w_rx_s  = r_sync[1];
    assign w_tick  = (r_tick_cnt == c_TICK_LAST);
    assign w_vote  = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);
    assign rx_busy = (r_state != ST_IDLE);

    // The three mid-bit samples land in r_samp on the MID tick; the vote is
    // acted on in the following clk (r_decide), when all three are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sync     <= 2'b11;
            r_tick_cnt <= '0;
            r_samp_cnt <= '0;
            r_bit_cnt  <= '0;
            r_samp     <= '0;
            r_decide   <= 1'b0;
            r_shift    <= '0;
            data_o     <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], rx};
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + c_TICK_W'(1);
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            r_decide   <= 1'b0;

            if (w_tick && r_state != ST_IDLE) begin
                r_samp_cnt <= (r_samp_cnt == c_SAMP_LAST) ? '0 : r_samp_cnt + c_SAMP_W'(1);
                if (r_samp_cnt == c_MID_M2 || r_samp_cnt == c_MID_M1 || r_samp_cnt == c_MID)
                    r_samp <= {r_samp[1:0], w_rx_s};
                if (r_samp_cnt == c_MID)
                    r_decide <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_tick && !w_rx_s) begin
                        r_state    <= ST_START;
                        r_samp_cnt <= '0;
                        r_bit_cnt  <= '0;
                    end
                end
                ST_START: begin
                    if (r_decide && w_vote)
                        r_state <= ST_IDLE;
                    else if (w_tick && r_samp_cnt == c_SAMP_LAST)
                        r_state <= ST_DATA;
                end
                ST_DATA: begin
                    if (r_decide)
                        r_shift <= {w_vote, r_shift[DATA_WIDTH-1:1]};
                    if (w_tick && r_samp_cnt == c_SAMP_LAST) begin
                        if (r_bit_cnt == c_BIT_LAST)
                            r_state <= ST_STOP;
                        else
                            r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                    end
                end
                ST_STOP: begin
                    // Leave at mid stop bit so a start edge right after it is caught.
                    if (r_decide) begin
                        r_state <= ST_IDLE;
                        if (w_vote) begin
                            data_o     <= r_shift;
                            data_valid <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int LAT       = 156;   // strobe cycle relative to first start-bit sample
    localparam int FRAME_CYC = 160;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data_o;
    logic       data_valid;
    logic       frame_err;
    logic       rx_busy;

    uart_rx #(
        .DATA_WIDTH   (8),
        .BAUDRATE     (62500),
        .CLK_FREQ_MHZ (1),
        .OVERSAMPLE   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_o     (data_o),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int         c;
        logic [7:0] d;
        bit         err;
    } ev_t;

    ev_t evq[$];
    int  both_cnt  = 0;
    int  busy_seen = 0;
    int  tests_run = 0;
    int  tests_failed = 0;
    int  frame_p;
    logic [7:0] last_good = 8'h00;

    always @(negedge clk) begin
        if (data_valid === 1'b1) evq.push_back('{c: cyc, d: data_o, err: 1'b0});
        if (frame_err === 1'b1)  evq.push_back('{c: cyc, d: data_o, err: 1'b1});
        if (data_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
        if (rx_busy === 1'b1) busy_seen++;
    end

    // Drives the first ncyc cycles of an 8N1 frame, 16 clk per bit.
    task automatic drive_frame(input logic [7:0] d, input logic stop, input bit glitch, input int ncyc);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (i == 0) frame_p = cyc + 1;
            rx = bits[i / 16] ^ (glitch && (i % 16) == 9);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (data_o !== 8'h00) begin tests_failed++; $display("FAIL reset_data_o got=%h exp=00", data_o); end
        tests_run++;
        if (data_valid !== 1'b0 || frame_err !== 1'b0) begin
            tests_failed++; $display("FAIL reset_strobes got valid=%b err=%b exp=0/0", data_valid, frame_err);
        end
        tests_run++;
        if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
        evq.delete();
        busy_seen = 0;
        idle(500);
        tests_run++;
        if (evq.size() !== 0) begin tests_failed++; $display("FAIL reset_idle_strobes got=%0d exp=0", evq.size()); end
        tests_run++;
        if (busy_seen !== 0) begin tests_failed++; $display("FAIL reset_idle_busy got=%0d exp=0", busy_seen); end
    endtask

    task automatic test_single;
        int p;
        evq.delete();
        drive_frame(8'hA5, 1'b1, 1'b0, FRAME_CYC);
        p = frame_p;
        idle(20);
        last_good = 8'hA5;
        tests_run++;
        if (evq.size() !== 1) begin tests_failed++; $display("FAIL single_count got=%0d exp=1", evq.size()); end
        if (evq.size() >= 1) begin
            tests_run++;
            if (evq[0].c !== p + LAT) begin tests_failed++; $display("FAIL single_time got=%0d exp=%0d", evq[0].c - p, LAT); end
            tests_run++;
            if (evq[0].d !== 8'hA5 || evq[0].err !== 1'b0) begin
                tests_failed++; $display("FAIL single_data got=%h err=%b exp=a5 err=0", evq[0].d, evq[0].err);
            end
        end
    endtask

    task automatic test_back_to_back;
        int p0;
        evq.delete();
        drive_frame(8'h00, 1'b1, 1'b0, FRAME_CYC);
        p0 = frame_p;
        drive_frame(8'hFF, 1'b1, 1'b0, FRAME_CYC);
        idle(20);
        last_good = 8'hFF;
        tests_run++;
        if (evq.size() !== 2) begin tests_failed++; $display("FAIL b2b_count got=%0d exp=2", evq.size()); end
        if (evq.size() == 2) begin
            tests_run++;
            if (evq[0].c !== p0 + LAT || evq[1].c - evq[0].c !== FRAME_CYC) begin
                tests_failed++;
                $display("FAIL b2b_time got=%0d,%0d exp=%0d,%0d", evq[0].c - p0, evq[1].c - evq[0].c, LAT, FRAME_CYC);
            end
            tests_run++;
            if (evq[0].d !== 8'h00 || evq[1].d !== 8'hFF || evq[0].err || evq[1].err) begin
                tests_failed++; $display("FAIL b2b_data got=%h,%h exp=00,ff", evq[0].d, evq[1].d);
            end
        end
    endtask

    task automatic test_glitch;
        int p;
        evq.delete();
        busy_seen = 0;
        repeat (3) begin @(negedge clk); rx = 1'b0; end
        idle(100);
        tests_run++;
        if (evq.size() !== 0) begin tests_failed++; $display("FAIL false_start_strobe got=%0d exp=0", evq.size()); end
        tests_run++;
        if (busy_seen == 0 || rx_busy !== 1'b0) begin
            tests_failed++; $display("FAIL false_start_busy got seen=%0d now=%b exp seen>0 now=0", busy_seen, rx_busy);
        end
        drive_frame(8'h3C, 1'b1, 1'b1, FRAME_CYC);
        p = frame_p;
        idle(20);
        last_good = 8'h3C;
        tests_run++;
        if (evq.size() !== 1) begin tests_failed++; $display("FAIL noisy_count got=%0d exp=1", evq.size()); end
        else begin
            tests_run++;
            if (evq[0].d !== 8'h3C || evq[0].err || evq[0].c !== p + LAT) begin
                tests_failed++; $display("FAIL noisy_data got=%h err=%b t=%0d exp=3c err=0 t=%0d", evq[0].d, evq[0].err, evq[0].c - p, LAT);
            end
        end
    endtask

    task automatic test_framing;
        int p;
        evq.delete();
        drive_frame(8'h55, 1'b0, 1'b0, FRAME_CYC);
        p = frame_p;
        idle(40);
        tests_run++;
        if (evq.size() !== 1) begin tests_failed++; $display("FAIL ferr_count got=%0d exp=1", evq.size()); end
        else begin
            tests_run++;
            if (evq[0].err !== 1'b1 || evq[0].c !== p + LAT) begin
                tests_failed++; $display("FAIL ferr_pulse got err=%b t=%0d exp err=1 t=%0d", evq[0].err, evq[0].c - p, LAT);
            end
        end
        tests_run++;
        if (data_o !== last_good) begin tests_failed++; $display("FAIL ferr_hold got=%h exp=%h", data_o, last_good); end
        evq.delete();
        drive_frame(8'h12, 1'b1, 1'b0, FRAME_CYC);
        idle(20);
        last_good = 8'h12;
        tests_run++;
        if (evq.size() !== 1 || data_o !== 8'h12) begin
            tests_failed++; $display("FAIL ferr_recover got n=%0d d=%h exp n=1 d=12", evq.size(), data_o);
        end
        else begin
            tests_run++;
            if (evq[0].err !== 1'b0) begin tests_failed++; $display("FAIL ferr_recover_err got=1 exp=0"); end
        end
    endtask

    task automatic test_reset_midframe;
        evq.delete();
        drive_frame(8'($urandom), 1'b1, 1'b0, 16 * 5 + 8);
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        last_good = 8'h00;
        tests_run++;
        if (rx_busy !== 1'b0 || data_o !== 8'h00) begin
            tests_failed++; $display("FAIL midrst_state got busy=%b d=%h exp busy=0 d=00", rx_busy, data_o);
        end
        idle(300);
        tests_run++;
        if (evq.size() !== 0) begin tests_failed++; $display("FAIL midrst_strobe got=%0d exp=0", evq.size()); end
        drive_frame(8'h81, 1'b1, 1'b0, FRAME_CYC);
        idle(20);
        last_good = 8'h81;
        tests_run++;
        if (evq.size() !== 1 || data_o !== 8'h81) begin
            tests_failed++; $display("FAIL midrst_next got n=%0d d=%h exp n=1 d=81", evq.size(), data_o);
        end
    endtask

    // Frames of random content/stop/noise/gap, or the 0..255 loopback sequence.
    task automatic test_stream(input bit loopback, input int nframes);
        ev_t exp_q[$];
        logic [7:0] d;
        logic stop;
        bit glitch;
        int n;
        evq.delete();
        for (int i = 0; i < nframes; i++) begin
            d      = loopback ? 8'(i) : 8'($urandom);
            stop   = loopback ? 1'b1 : ($urandom_range(0, 3) != 0);
            glitch = loopback ? 1'b0 : bit'($urandom_range(0, 1));
            drive_frame(d, stop, glitch, FRAME_CYC);
            if (stop) last_good = d;
            exp_q.push_back('{c: frame_p + LAT, d: last_good, err: !stop});
            idle(stop ? $urandom_range(0, 8) : $urandom_range(30, 50));
        end
        idle(20);
        tests_run++;
        if (evq.size() !== exp_q.size()) begin
            tests_failed++; $display("FAIL stream%0d_count got=%0d exp=%0d", loopback, evq.size(), exp_q.size());
        end
        n = (evq.size() < exp_q.size()) ? evq.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            tests_run++;
            if (evq[i].d !== exp_q[i].d || evq[i].err !== exp_q[i].err || evq[i].c !== exp_q[i].c) begin
                tests_failed++;
                $display("FAIL stream%0d_frame%0d got d=%h err=%b t=%0d exp d=%h err=%b t=%0d",
                         loopback, i, evq[i].d, evq[i].err, evq[i].c, exp_q[i].d, exp_q[i].err, exp_q[i].c);
            end
        end
    endtask

    task automatic test_exclusive;
        tests_run++;
        if (both_cnt !== 0) begin tests_failed++; $display("FAIL strobe_exclusive got=%0d exp=0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_midframe();
        test_stream(1'b0, 24);
        test_stream(1'b1, 256);
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
